// File: rtl/mem_align_defs_pkg.sv
// Shared MemAlign encodings and BRAM byte-enable constants for the memory stage.
package mem_align_defs;

    localparam logic [1:0] ALIGN_BYTE = 2'b00;
    localparam logic [1:0] ALIGN_HALF = 2'b01;
    localparam logic [1:0] ALIGN_WORD = 2'b10;
    localparam logic [1:0] ALIGN_ILL  = 2'b11;

    localparam logic [3:0] WE_NONE    = 4'b0000;
    localparam logic [3:0] WE_LO_HALF = 4'b0011;
    localparam logic [3:0] WE_HI_HALF = 4'b1100;
    localparam logic [3:0] WE_WORD    = 4'b1111;

    function automatic logic [3:0] byte_lane_we(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data BRAM port bundle: the stage is master, the memory model/BRAM is slave.
interface mem_access_stage_if #(
    parameter int ADDR_W = 14
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_en, mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_stage_load_extract.sv
// Combinational load alignment: picks the byte/half lane and sign- or zero-extends.
module load_extract
    import mem_align_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  align,
    input  logic        is_unsigned,
    output logic [31:0] load_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{off, 3'b000} +: 8];
        half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (align)
            ALIGN_BYTE: load_data = {{24{!is_unsigned & byte_sel[7]}}, byte_sel};
            ALIGN_HALF: load_data = {{16{!is_unsigned & half_sel[15]}}, half_sel};
            default:    load_data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: drives the data BRAM, aligns returned load data, holds it across stalls.
// Optional misalignment counter port err_count is enabled by defining MEM_ERR_CNT_EN.
module mem_access_stage
    import mem_align_defs::*;
#(
    parameter int ADDR_W    = 14,
    parameter int ERR_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  stall,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [1:0]            mem_align,
    input  logic                  load_unsigned,
    input  logic [31:0]           addr,
    input  logic [31:0]           store_data,
    mem_access_stage_if.master    bram,
    output logic [31:0]           load_data,
    output logic                  load_valid,
`ifdef MEM_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0]  err_count,
`endif
    output logic                  misaligned
);
    logic        accept, mis;
    logic        r_valid_q, r_valid_d;
    logic [1:0]  r_off_q, r_off_d;
    logic [1:0]  r_align_q, r_align_d;
    logic        r_unsigned_q, r_unsigned_d;
    logic        r_mis_q, r_mis_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] eff_rdata, extracted;

    always_comb begin
        accept = valid_in & !stall & (is_load | is_store);
        case (mem_align)
            ALIGN_HALF: mis = addr[0];
            ALIGN_WORD: mis = (addr[1:0] != 2'b00);
            ALIGN_ILL:  mis = 1'b1;
            default:    mis = 1'b0;
        endcase
    end

    always_comb begin
        bram.mem_en    = accept & !mis;
        bram.mem_addr  = addr[ADDR_W+1:2];
        bram.mem_we    = WE_NONE;
        bram.mem_wdata = store_data;
        case (mem_align)
            ALIGN_BYTE: begin
                bram.mem_we    = byte_lane_we(addr[1:0]);
                bram.mem_wdata = {4{store_data[7:0]}};
            end
            ALIGN_HALF: begin
                bram.mem_we    = addr[1] ? WE_HI_HALF : WE_LO_HALF;
                bram.mem_wdata = {2{store_data[15:0]}};
            end
            ALIGN_WORD: bram.mem_we = WE_WORD;
            default:    bram.mem_we = WE_NONE;
        endcase
        if (!(accept & is_store & !mis))
            bram.mem_we = WE_NONE;
    end

    // Stage registers freeze while stalled; the hold buffer grabs the one-cycle BRAM data.
    always_comb begin
        r_valid_d    = r_valid_q;
        r_off_d      = r_off_q;
        r_align_d    = r_align_q;
        r_unsigned_d = r_unsigned_q;
        r_mis_d      = r_mis_q;
        hold_valid_d = 1'b0;
        hold_data_d  = hold_data_q;
        if (!stall) begin
            r_valid_d    = valid_in & is_load;
            r_off_d      = addr[1:0];
            r_align_d    = mem_align;
            r_unsigned_d = load_unsigned;
            r_mis_d      = accept & mis;
        end else begin
            hold_valid_d = hold_valid_q | r_valid_q;
            if (r_valid_q && !hold_valid_q)
                hold_data_d = bram.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q    <= 1'b0;
            r_off_q      <= 2'b00;
            r_align_q    <= 2'b00;
            r_unsigned_q <= 1'b0;
            r_mis_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 32'h0;
        end else begin
            r_valid_q    <= r_valid_d;
            r_off_q      <= r_off_d;
            r_align_q    <= r_align_d;
            r_unsigned_q <= r_unsigned_d;
            r_mis_q      <= r_mis_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign eff_rdata = hold_valid_q ? hold_data_q : bram.mem_rdata;

    load_extract u_load_extract (
        .rdata       (eff_rdata),
        .off         (r_off_q),
        .align       (r_align_q),
        .is_unsigned (r_unsigned_q),
        .load_data   (extracted)
    );

    assign load_valid = r_valid_q;
    assign load_data  = (r_valid_q && !r_mis_q) ? extracted : 32'h0;
    assign misaligned = r_mis_q;

`ifdef MEM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && mis && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: BRAM-side outputs checked against a lane model,
// load results pushed to a scoreboard queue at issue and popped when the DUT presents them.
module tb_mem_access_stage;
    localparam int ADDR_W    = 14;
    localparam int ERR_CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, stall, is_load, is_store, load_unsigned;
    logic [1:0]  mem_align;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        load_valid, misaligned;
`ifdef MEM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_count;
    int                   exp_err = 0;
`endif

    typedef struct {
        logic        lv;
        logic [31:0] ld;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mem_access_stage_if #(.ADDR_W(ADDR_W)) bram ();

    mem_access_stage #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .stall         (stall),
        .is_load       (is_load),
        .is_store      (is_store),
        .mem_align     (mem_align),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .store_data    (store_data),
        .bram          (bram.master),
        .load_data     (load_data),
        .load_valid    (load_valid),
`ifdef MEM_ERR_CNT_EN
        .err_count     (err_count),
`endif
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] al, input logic [1:0] off);
        if (al == 2'b11) return 1'b1;
        if (al == 2'b10) return off != 2'b00;
        if (al == 2'b01) return off[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [1:0] al, input logic uns);
        logic [31:0] sh;
        sh = rd >> (8 * off);
        if (al == 2'b00) return uns ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
        if (al == 2'b01) return uns ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
        return rd;
    endfunction

    // Drives one request, checks the BRAM side, then checks the load result a cycle later.
    task automatic applyStimulus(input string tag, input logic ld, input logic [1:0] al,
                                 input logic uns, input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd);
        logic        m;
        logic [3:0]  we;
        logic [31:0] wd;
        exp_t        e, g;
        @(negedge clk);
        valid_in = 1'b1; is_load = ld; is_store = !ld; mem_align = al;
        load_unsigned = uns; addr = a; store_data = sd; bram.mem_rdata = 32'h0;
        m  = model_mis(al, a[1:0]);
        we = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (!ld && !m && (al == 2'b10 || (al == 2'b01 && (i / 2) == int'(a[1])) ||
                              (al == 2'b00 && i == int'(a[1:0]))))
                we[i] = 1'b1;
        wd = (al == 2'b00) ? sd[7:0] * 32'h01010101 :
             (al == 2'b01) ? sd[15:0] * 32'h00010001 : sd;
        #1;
        checkOutput({tag, ".mem_en"},   32'(bram.mem_en),   32'(!m));
        checkOutput({tag, ".mem_addr"}, 32'(bram.mem_addr), (a >> 2) & 32'h3FFF);
        checkOutput({tag, ".mem_we"},   32'(bram.mem_we),   32'(we));
        if (!ld && !m) checkOutput({tag, ".mem_wdata"}, bram.mem_wdata, wd);
        e.lv  = ld;
        e.mis = m;
        e.ld  = (ld && !m) ? model_load(rd, a[1:0], al, uns) : 32'h0;
        sb.push_back(e);
`ifdef MEM_ERR_CNT_EN
        if (m) exp_err++;
`endif
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        bram.mem_rdata = rd;
        #1;
        g = sb.pop_front();
        checkOutput({tag, ".load_valid"}, 32'(load_valid), 32'(g.lv));
        checkOutput({tag, ".load_data"},  load_data,       g.ld);
        checkOutput({tag, ".misaligned"}, 32'(misaligned), 32'(g.mis));
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; stall = 1'b0; is_load = 1'b0; is_store = 1'b0;
        mem_align = 2'b00; load_unsigned = 1'b0; addr = 32'h0; store_data = 32'h0;
        bram.mem_rdata = 32'h0;
        #12;
        checkOutput("rst.load_valid", 32'(load_valid), 32'h0);
        checkOutput("rst.load_data",  load_data,       32'h0);
        checkOutput("rst.misaligned", 32'(misaligned), 32'h0);
        rst_n = 1'b1;

        applyStimulus("sb_1003",  1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0);
        applyStimulus("lh_signed",1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234);
        applyStimulus("lhu",      1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234);
        applyStimulus("lb_off1",  1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_7F00);
        applyStimulus("lb_off0",  1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0080);
        applyStimulus("lbu_off3", 1'b1, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'hF000_0000);
        applyStimulus("lw_ok",    1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF);
        applyStimulus("sh_hi",    1'b0, 2'b01, 1'b0, 32'h0000_0402, 32'hABCD_1234, 32'h0);
        applyStimulus("sw_ok",    1'b0, 2'b10, 1'b0, 32'h0000_0504, 32'hCAFE_F00D, 32'h0);
        applyStimulus("lw_off2",  1'b1, 2'b10, 1'b0, 32'h0000_0602, 32'h0, 32'h1234_5678);
        applyStimulus("sw_off1",  1'b0, 2'b10, 1'b0, 32'h0000_0701, 32'h5555_AAAA, 32'h0);
        applyStimulus("lh_off1",  1'b1, 2'b01, 1'b0, 32'h0000_0801, 32'h0, 32'hFFFF_FFFF);
        applyStimulus("ill_align",1'b1, 2'b11, 1'b0, 32'h0000_0900, 32'h0, 32'h0);
        applyStimulus("sb_rand",  1'b0, 2'b00, 1'b0, {$urandom} & 32'hFFFF, $urandom, 32'h0);

`ifdef MEM_ERR_CNT_EN
        checkOutput("err_count", 32'(err_count), 32'(exp_err));
`endif

        // Stalled load: BRAM data changes under the stall but the first beat must be held.
        @(negedge clk);
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; mem_align = 2'b10;
        load_unsigned = 1'b0; addr = 32'h0000_0A00;
        @(posedge clk);
        #1;
        stall = 1'b1; is_load = 1'b0; is_store = 1'b1; store_data = 32'h9999_9999;
        bram.mem_rdata = 32'h1111_1111;
        #1;
        checkOutput("stall0.load_data", load_data, 32'h1111_1111);
        checkOutput("stall0.mem_en",    32'(bram.mem_en), 32'h0);
        checkOutput("stall0.mem_we",    32'(bram.mem_we), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            bram.mem_rdata = 32'h2222_2222;
            #1;
            checkOutput($sformatf("stall%0d.load_data", i), load_data, 32'h1111_1111);
            checkOutput($sformatf("stall%0d.load_valid", i), 32'(load_valid), 32'h1);
            checkOutput($sformatf("stall%0d.mem_en", i), 32'(bram.mem_en), 32'h0);
        end

        @(negedge clk);
        #2;
        bram.mem_rdata = 32'h0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid.load_valid", 32'(load_valid), 32'h0);
        checkOutput("rst_mid.misaligned", 32'(misaligned), 32'h0);
        checkOutput("rst_mid.load_data",  load_data,       32'h0);
`ifdef MEM_ERR_CNT_EN
        checkOutput("rst_mid.err_count", 32'(err_count), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; valid_in = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
